// File: rtl/rpn_stack_core.sv
// RPN evaluation core: a register-file operand stack and a small ALU behind a valid/ready command port.
// Pushes complete in one cycle. Operations take the LOAD/EXEC/WRITE path. Illegal commands park the core in a sticky ERROR state.
module rpn_stack_core #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_is_op,
    input  logic [2:0]                   cmd_op,
    input  logic [WIDTH-1:0]             cmd_data,
    input  logic                         clr_err,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         err,
    output logic [1:0]                   err_code
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_DUP  = 3'd6;
    localparam logic [2:0] OP_SWAP = 3'd7;

    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_WRITE,
        S_ERROR
    } state_t;

    state_t state;
    state_t next_state;

    logic [DEPTH-1:0][WIDTH-1:0] entries;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;

    logic accept;
    logic underflow;
    logic overflow;

    logic [AW-1:0] idx_push;
    logic [AW-1:0] idx_b;
    logic [AW-1:0] idx_a;

    // Slot for the next push, B (top entry) and A (entry below B).
    assign idx_push = AW'(depth);
    assign idx_b    = AW'(depth - DW'(1));
    assign idx_a    = AW'(depth - DW'(2));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, ready decode and legality check on the current depth.
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        accept     = 1'b0;
        underflow  = 1'b0;
        overflow   = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_is_op) begin
                        if (cmd_op == OP_DUP) begin
                            underflow = (depth == '0);
                            overflow  = (depth == DW'(DEPTH));
                        end else begin
                            underflow = (depth < DW'(2));
                        end
                    end else begin
                        overflow = (depth == DW'(DEPTH));
                    end
                    if (underflow || overflow) begin
                        next_state = S_ERROR;
                    end else if (cmd_is_op) begin
                        next_state = S_LOAD;
                    end
                end
            end
            S_LOAD:  next_state = S_EXEC;
            S_EXEC:  next_state = S_WRITE;
            S_WRITE: next_state = S_IDLE;
            S_ERROR: begin
                if (clr_err) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Stack, operand, result and error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entries  <= '0;
            depth    <= '0;
            top      <= '0;
            err      <= 1'b0;
            err_code <= 2'd0;
            op_q     <= 3'd0;
            opa      <= '0;
            opb      <= '0;
            res      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (underflow) begin
                            err      <= 1'b1;
                            err_code <= ERR_UNDER;
                        end else if (overflow) begin
                            err      <= 1'b1;
                            err_code <= ERR_OVER;
                        end else if (!cmd_is_op) begin
                            entries[idx_push] <= cmd_data;
                            depth             <= depth + DW'(1);
                            top               <= cmd_data;
                        end else begin
                            op_q <= cmd_op;
                        end
                    end
                end
                S_LOAD: begin
                    opb <= entries[idx_b];
                    opa <= (depth >= DW'(2)) ? entries[idx_a] : '0;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_ADD:  res <= opa + opb;
                        OP_SUB:  res <= opa - opb;
                        OP_MUL:  res <= WIDTH'(opa * opb);
                        OP_AND:  res <= opa & opb;
                        OP_OR:   res <= opa | opb;
                        OP_XOR:  res <= opa ^ opb;
                        OP_DUP:  res <= opb;
                        OP_SWAP: res <= opa;
                        default: res <= '0;
                    endcase
                end
                S_WRITE: begin
                    // res always holds the value that becomes the new top entry.
                    top <= res;
                    if (op_q == OP_DUP) begin
                        entries[idx_push] <= res;
                        depth             <= depth + DW'(1);
                    end else if (op_q == OP_SWAP) begin
                        entries[idx_b] <= res;
                        entries[idx_a] <= opb;
                    end else begin
                        entries[idx_a] <= res;
                        depth          <= depth - DW'(1);
                    end
                end
                S_ERROR: begin
                    if (clr_err) begin
                        err      <= 1'b0;
                        err_code <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_core.sv
// Self-checking bench for rpn_stack_core (WIDTH=8, DEPTH=4). It runs directed test-plan sequences and then random commands.
// The reference is a queue-based RPN stack model.
module tb_rpn_stack_core;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned DW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_is_op = 1'b0;
    logic [2:0]    cmd_op = 3'd0;
    logic [W-1:0]  cmd_data = '0;
    logic          clr_err = 1'b0;
    logic [W-1:0]  top;
    logic [DW-1:0] depth;
    logic          err;
    logic [1:0]    err_code;

    int n_tests = 0;
    int n_fail  = 0;

    int mdl[$];
    bit merr = 1'b0;
    int mcode = 0;

    rpn_stack_core #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_is_op (cmd_is_op),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .clr_err   (clr_err),
        .top       (top),
        .depth     (depth),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic check_state(input string tag);
        check({tag, "_depth"}, int'(depth), mdl.size());
        check({tag, "_top"}, int'(top), (mdl.size() > 0) ? mdl[mdl.size()-1] : 0);
        check({tag, "_err"}, int'(err), int'(merr));
        check({tag, "_code"}, int'(err_code), mcode);
        check({tag, "_ready"}, int'(cmd_ready), merr ? 0 : 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        clr_err   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl.delete();
        merr  = 1'b0;
        mcode = 0;
        check_state("reset");
    endtask

    // Issue one command from a negedge while the core is idle, and update the model.
    task automatic send(input bit is_op, input int op, input int d);
        int  n;
        int  a;
        int  b;
        int  r;
        bit  legal_op;
        n        = mdl.size();
        legal_op = 1'b0;
        cmd_valid = 1'b1;
        cmd_is_op = is_op;
        cmd_op    = 3'(op);
        cmd_data  = 8'(d);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom_range(0, 255));
        cmd_op    = 3'($urandom_range(0, 7));
        if (is_op) begin
            if ((op == 6 && n == 0) || (op != 6 && n < 2)) begin
                merr = 1'b1; mcode = 1;
            end else if (op == 6 && n == D) begin
                merr = 1'b1; mcode = 2;
            end else begin
                legal_op = 1'b1;
                case (op)
                    6: mdl.push_back(mdl[n-1]);
                    7: begin
                        b = mdl[n-1];
                        mdl[n-1] = mdl[n-2];
                        mdl[n-2] = b;
                    end
                    default: begin
                        b = mdl.pop_back();
                        a = mdl.pop_back();
                        case (op)
                            0: r = a + b;
                            1: r = a - b;
                            2: r = a * b;
                            3: r = a & b;
                            4: r = a | b;
                            default: r = a ^ b;
                        endcase
                        mdl.push_back(r & 255);
                    end
                endcase
            end
        end else if (n == D) begin
            merr = 1'b1; mcode = 2;
        end else begin
            mdl.push_back(d);
        end
        if (legal_op) begin
            for (int i = 0; i < 3; i++) begin
                check("busy_ready", int'(cmd_ready), 0);
                @(negedge clk);
            end
        end
        check_state(is_op ? "op" : "push");
    endtask

    // While in ERROR, check that a held push is ignored, then pulse clr_err (optionally with a push).
    task automatic clear(input bit with_push);
        cmd_valid = 1'b1;
        cmd_is_op = 1'b0;
        cmd_data  = 8'd6;
        @(negedge clk);
        check_state("err_hold");
        clr_err   = 1'b1;
        cmd_valid = with_push;
        @(negedge clk);
        clr_err   = 1'b0;
        cmd_valid = 1'b0;
        merr  = 1'b0;
        mcode = 0;
        check_state("clr");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Add, then a subtract that wraps.
        send(0, 0, 5);
        send(0, 0, 3);
        send(1, 0, 0);
        check("plan_add_top", int'(top), 8);
        send(0, 0, 10);
        send(1, 1, 0);
        check("plan_sub_top", int'(top), 254);

        // Multiply and XOR.
        send(0, 0, 200);
        send(0, 0, 3);
        send(1, 2, 0);
        check("plan_mul_top", int'(top), 88);
        send(0, 0, 15);
        send(1, 5, 0);
        check("plan_xor_top", int'(top), 'h57);

        // DUP, SWAP, AND.
        do_reset();
        send(0, 0, 7);
        send(1, 6, 0);
        check("plan_dup_depth", int'(depth), 2);
        send(1, 7, 0);
        check("plan_swap_depth", int'(depth), 2);
        send(1, 3, 0);
        check("plan_and_depth", int'(depth), 1);
        check("plan_and_top", int'(top), 7);

        // Overflow, then clear.
        do_reset();
        for (int i = 1; i <= 4; i++) send(0, 0, i);
        send(0, 0, 9);
        check("plan_ovf_code", int'(err_code), 2);
        check("plan_ovf_top", int'(top), 4);
        clear(1'b0);

        // Underflow, then clear together with a push that must be ignored.
        do_reset();
        send(0, 0, 1);
        send(1, 0, 0);
        check("plan_unf_code", int'(err_code), 1);
        clear(1'b1);
        check("plan_clr_depth", int'(depth), 1);

        // clr_err outside ERROR has no effect.
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_state("idle_clr");

        // Reset during EXEC aborts the operation.
        do_reset();
        send(0, 0, 20);
        send(0, 0, 30);
        cmd_valid = 1'b1;
        cmd_is_op = 1'b1;
        cmd_op    = 3'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl.delete();
        merr  = 1'b0;
        mcode = 0;
        check_state("rst_mid");
        repeat (4) @(negedge clk);
        check_state("rst_after");

        // Random commands against the model.
        for (int it = 0; it < 400; it++) begin
            if (merr) begin
                clear(1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 9) < 5) begin
                send(0, 0, int'($urandom_range(0, 255)));
            end else begin
                send(1, int'($urandom_range(0, 7)), 0);
            end
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
